// File: rtl/sar_result_capture_if.sv
// Sample stream from the SAR result capture block to the downstream consumer.
// The master drives code, saturation flag and valid. The slave drives ready.
interface sar_result_capture_if #(
    parameter int unsigned NOB = 10
);
    logic [NOB-1:0] dout_data;
    logic           dout_sat;
    logic           dout_valid;
    logic           dout_ready;

    modport master (
        output dout_data,
        output dout_sat,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout_data,
        input  dout_sat,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/sar_result_capture.sv
// Captures one SAR code per EOC rising edge into a small tagged FIFO.
// Adds a level count, a sticky overflow flag and a wrapping conversion counter.
module sar_result_capture #(
    parameter int unsigned NOB   = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NOB-1:0]           digital_out,
    input  logic                     EOC,
    sar_result_capture_if.master     res,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [CNTW-1:0]          conv_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic          eoc_d;
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [NOB:0]  mem [DEPTH];

    logic          rise;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          sat;
    logic [NOB:0]  head;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(DEPTH));
    assign rise  = EOC & ~eoc_d;
    assign sat   = (digital_out == '0) || (digital_out == '1);
    assign pop   = res.dout_valid & res.dout_ready;
    assign push  = rise & (~full | pop);
    assign drop  = rise & full & ~pop;

    assign head           = mem[rd_ptr[AW-1:0]];
    assign res.dout_valid = (level != '0);
    assign res.dout_data  = res.dout_valid ? head[NOB-1:0] : '0;
    assign res.dout_sat   = res.dout_valid ? head[NOB] : 1'b0;

    // eoc_d resets high, so an EOC held through reset is not taken as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_d    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            conv_cnt <= '0;
        end else begin
            eoc_d <= EOC;
            if (push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (rise) begin
                conv_cnt <= conv_cnt + CNTW'(1);
            end
        end
    end

    // Storage holds no reset. Unwritten entries are never visible while valid is low.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= {sat, digital_out};
        end
    end
endmodule

// File: tb/tb_sar_result_capture.sv
// Directed vector bench for sar_result_capture: table-driven main checks plus
// a conversion counter wrap sequence on a narrow-counter instance.
module tb_sar_result_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance with the default parameters
    logic        rst, eoc, ovf_clr, ovf;
    logic [9:0]  dig;
    logic [2:0]  level;
    logic [15:0] conv_cnt;
    sar_result_capture_if #(.NOB(10)) res ();

    sar_result_capture #(.NOB(10), .DEPTH(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .digital_out(dig), .EOC(eoc), .res(res),
        .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .conv_cnt(conv_cnt)
    );

    // Instance with a 3-bit conversion counter, used for the wrap check
    logic        rst_b, eoc_b, clr_b, ovf_b;
    logic [9:0]  dig_b;
    logic [2:0]  level_b;
    logic [2:0]  cnt_b;
    sar_result_capture_if #(.NOB(10)) res_b ();

    sar_result_capture #(.NOB(10), .DEPTH(4), .CNTW(3)) dut_b (
        .clk(clk), .rst(rst_b), .digital_out(dig_b), .EOC(eoc_b), .res(res_b),
        .level(level_b), .ovf(ovf_b), .ovf_clr(clr_b), .conv_cnt(cnt_b)
    );

    typedef struct {
        logic        rst;
        logic        eoc;
        logic [9:0]  code;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [9:0]  ed;
        logic        es;
        logic [2:0]  el;
        logic        eo;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic void add(input logic r, input logic e, input int code,
                                input logic rdy, input logic clr, input logic ev,
                                input int ed, input logic es, input int el,
                                input logic eo, input int ec);
        vec_t v;
        v.rst = r;  v.eoc = e;  v.code = 10'(code); v.rdy = rdy; v.clr = clr;
        v.ev = ev;  v.ed = 10'(ed); v.es = es; v.el = 3'(el); v.eo = eo;
        v.ec = 16'(ec);
        vecs.push_back(v);
    endfunction

    task automatic check_b(input string name, input logic ev, input int ed,
                           input logic es, input int el, input logic eo, input int ec);
        applied++;
        if ({res_b.dout_valid, res_b.dout_data, res_b.dout_sat, level_b, ovf_b, cnt_b} !==
            {ev, 10'(ed), es, 3'(el), eo, 3'(ec)}) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%0d sat=%b level=%0d ovf=%b cnt=%0d, expected valid=%b data=%0d sat=%b level=%0d ovf=%b cnt=%0d",
                     name, res_b.dout_valid, res_b.dout_data, res_b.dout_sat, level_b, ovf_b,
                     cnt_b, ev, ed, es, el, eo, ec);
        end
    endtask

    initial begin
        rst = 1'b1; eoc = 1'b0; dig = '0; ovf_clr = 1'b0; res.dout_ready = 1'b0;
        rst_b = 1'b1; eoc_b = 1'b0; dig_b = '0; clr_b = 1'b0; res_b.dout_ready = 1'b0;

        //   rst eoc code rdy clr | valid data sat level ovf cnt
        // Single capture while EOC holds high for three edges
        add(1, 0, 0,    0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 0, 512,  0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 1, 512,  0, 0,   1, 512,  0, 1, 0, 1);
        add(0, 1, 512,  0, 0,   1, 512,  0, 1, 0, 1);
        add(0, 1, 512,  0, 0,   1, 512,  0, 1, 0, 1);
        add(0, 0, 512,  0, 0,   1, 512,  0, 1, 0, 1);
        // Saturation tagging with an always-ready consumer
        add(1, 0, 0,    0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0,    0, 0, 0, 0);
        add(0, 1, 0,    1, 0,   1, 0,    1, 1, 0, 1);
        add(0, 0, 0,    1, 0,   0, 0,    0, 0, 0, 1);
        add(0, 1, 1023, 1, 0,   1, 1023, 1, 1, 0, 2);
        add(0, 0, 1023, 1, 0,   0, 0,    0, 0, 0, 2);
        add(0, 1, 511,  1, 0,   1, 511,  0, 1, 0, 3);
        add(0, 0, 511,  1, 0,   0, 0,    0, 0, 0, 3);
        // Overflow on the fifth capture, drain, then ovf_clr
        add(1, 0, 0,    0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 0, 0,    0, 0,   0, 0,    0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            add(0, 1, i, 0, 0,  1, 1, 0, i, 0, i);
            add(0, 0, i, 0, 0,  1, 1, 0, i, 0, i);
        end
        add(0, 1, 5,    0, 0,   1, 1,    0, 4, 1, 5);
        add(0, 0, 5,    0, 0,   1, 1,    0, 4, 1, 5);
        add(0, 0, 0,    1, 0,   1, 2,    0, 3, 1, 5);
        add(0, 0, 0,    1, 0,   1, 3,    0, 2, 1, 5);
        add(0, 0, 0,    1, 0,   1, 4,    0, 1, 1, 5);
        add(0, 0, 0,    1, 0,   0, 0,    0, 0, 1, 5);
        add(0, 0, 0,    0, 1,   0, 0,    0, 0, 0, 5);
        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) begin
            add(0, 1, 10 + i, 0, 0,  1, 10, 0, i + 1, 0, 6 + i);
            add(0, 0, 10 + i, 0, 0,  1, 10, 0, i + 1, 0, 6 + i);
        end
        add(0, 1, 14,   1, 0,   1, 11,   0, 4, 0, 10);
        add(0, 0, 14,   1, 0,   1, 12,   0, 3, 0, 10);
        add(0, 0, 14,   1, 0,   1, 13,   0, 2, 0, 10);
        add(0, 0, 14,   1, 0,   1, 14,   0, 1, 0, 10);
        add(0, 0, 14,   1, 0,   0, 0,    0, 0, 0, 10);
        // Drop coincident with ovf_clr: the set wins
        for (int i = 0; i < 4; i++) begin
            add(0, 1, 20 + i, 0, 0,  1, 20, 0, i + 1, 0, 11 + i);
            add(0, 0, 20 + i, 0, 0,  1, 20, 0, i + 1, 0, 11 + i);
        end
        add(0, 1, 24,   0, 1,   1, 20,   0, 4, 1, 15);
        add(0, 0, 24,   0, 0,   1, 20,   0, 4, 1, 15);
        // EOC held high through reset is not captured
        add(1, 1, 100,  0, 0,   0, 0,    0, 0, 0, 0);
        add(1, 1, 100,  0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 1, 100,  0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 1, 100,  0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 0, 100,  0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 1, 100,  0, 0,   1, 100,  0, 1, 0, 1);
        add(0, 0, 100,  0, 0,   1, 100,  0, 1, 0, 1);
        add(0, 1, 101,  0, 0,   1, 100,  0, 2, 0, 2);
        add(0, 0, 101,  0, 0,   1, 100,  0, 2, 0, 2);
        add(0, 1, 102,  0, 0,   1, 100,  0, 3, 0, 3);
        // Reset with three entries stored
        add(1, 0, 0,    0, 0,   0, 0,    0, 0, 0, 0);
        add(0, 0, 0,    0, 0,   0, 0,    0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; eoc = vecs[i].eoc; dig = vecs[i].code;
            res.dout_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            applied++;
            if ({res.dout_valid, res.dout_data, res.dout_sat, level, ovf, conv_cnt} !==
                {vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].el, vecs[i].eo, vecs[i].ec}) begin
                miscompares++;
                $display("FAIL vec%0d: got valid=%b data=%0d sat=%b level=%0d ovf=%b cnt=%0d, expected valid=%b data=%0d sat=%b level=%0d ovf=%b cnt=%0d",
                         i, res.dout_valid, res.dout_data, res.dout_sat, level, ovf, conv_cnt,
                         vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].el, vecs[i].eo, vecs[i].ec);
            end
        end

        // Counter wrap on the 3-bit instance; every sample must still be delivered
        rst_b = 1'b1; res_b.dout_ready = 1'b1;
        @(posedge clk); #1;
        check_b("wrap_reset", 0, 0, 0, 0, 0, 0);
        rst_b = 1'b0;
        @(posedge clk); #1;
        check_b("wrap_idle", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            eoc_b = 1'b1; dig_b = 10'(i * 7);
            @(posedge clk); #1;
            check_b($sformatf("wrap_capture%0d", i), 1, i * 7, 0, 1, 0, i % 8);
            eoc_b = 1'b0;
            @(posedge clk); #1;
            check_b($sformatf("wrap_pop%0d", i), 0, 0, 0, 0, 0, i % 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
